// File: rtl/fifo_dual_reader.sv
// Burst reader draining a dual-port FIFO into two independent valid/ready channels.
// Optional build macro FIFO_DUAL_READER_LOCKSTEP_EN makes both ports pop only as a pair.
module fifo_dual_reader #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned BufferSize = 16,
  parameter int unsigned LenWidth   = 8
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  Start,
  input  logic [LenWidth-1:0]   Len,
  output logic                  Busy,
  output logic                  Done,
  input  logic                  Empty,
  input  logic [BufferSize-1:0] ReadyM,
  input  logic [DataWidth-1:0]  DataOut1,
  input  logic [DataWidth-1:0]  DataOut2,
  output logic                  Pop1,
  output logic                  Pop2,
  output logic                  P_Valid,
  output logic [DataWidth-1:0]  P_Data,
  input  logic                  P_Ready,
  output logic                  M_Valid,
  output logic [DataWidth-1:0]  M_Data,
  input  logic                  M_Ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [LenWidth-1:0]   r_rem_p;
  logic [LenWidth-1:0]   r_rem_m;
  logic                  r_p_valid;
  logic                  r_m_valid;
  logic [DataWidth-1:0]  r_p_data;
  logic [DataWidth-1:0]  r_m_data;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_run;
  logic                  w_p_ok;
  logic                  w_m_ok;
  logic                  w_pop_p;
  logic                  w_pop_m;
  logic [LenWidth-1:0]   w_rem_p_nxt;
  logic [LenWidth-1:0]   w_rem_m_nxt;

  // A port may pop when its FIFO side has data, words remain and its output slot frees this edge.
  assign w_run  = (r_state == ST_RUN);
  assign w_p_ok = w_run & ~Empty & (r_rem_p != '0) & (~r_p_valid | P_Ready);
  assign w_m_ok = w_run & (|ReadyM) & (r_rem_m != '0) & (~r_m_valid | M_Ready);

`ifdef FIFO_DUAL_READER_LOCKSTEP_EN
  assign w_pop_p = w_p_ok & w_m_ok;
  assign w_pop_m = w_p_ok & w_m_ok;
`else
  assign w_pop_p = w_p_ok;
  assign w_pop_m = w_m_ok;
`endif

  // Pop is gated by a nonzero count, so the decrement cannot wrap.
  assign w_rem_p_nxt = w_pop_p ? (r_rem_p - LenWidth'(1)) : r_rem_p;
  assign w_rem_m_nxt = w_pop_m ? (r_rem_m - LenWidth'(1)) : r_rem_m;

  assign Pop1    = w_pop_p;
  assign Pop2    = w_pop_m;
  assign P_Valid = r_p_valid;
  assign M_Valid = r_m_valid;
  assign P_Data  = r_p_data;
  assign M_Data  = r_m_data;
  assign Busy    = r_busy;
  assign Done    = r_done;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_state   <= ST_IDLE;
      r_rem_p   <= '0;
      r_rem_m   <= '0;
      r_p_valid <= 1'b0;
      r_m_valid <= 1'b0;
      r_p_data  <= '0;
      r_m_data  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // Output slots: a pop refills, an accepted word without refill empties.
      if (w_pop_p) begin
        r_p_data  <= DataOut1;
        r_p_valid <= 1'b1;
      end else if (r_p_valid && P_Ready) begin
        r_p_valid <= 1'b0;
      end
      if (w_pop_m) begin
        r_m_data  <= DataOut2;
        r_m_valid <= 1'b1;
      end else if (r_m_valid && M_Ready) begin
        r_m_valid <= 1'b0;
      end

      r_rem_p <= w_rem_p_nxt;
      r_rem_m <= w_rem_m_nxt;
      r_done  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_rem_p <= Len;
            r_rem_m <= Len;
            r_busy  <= 1'b1;
            if (Len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if ((w_rem_p_nxt == '0) && (w_rem_m_nxt == '0)) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (!r_p_valid && !r_m_valid) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_dual_reader.sv
// Scoreboard bench for fifo_dual_reader: a FIFO model feeds both ports, a monitor checks delivered words.
module tb_fifo_dual_reader;

  logic        clk;
  logic        aclr;
  logic        Start;
  logic [7:0]  Len;
  logic        Busy;
  logic        Done;
  logic        Empty;
  logic [15:0] ReadyM;
  logic [31:0] DataOut1;
  logic [31:0] DataOut2;
  logic        Pop1;
  logic        Pop2;
  logic        P_Valid;
  logic [31:0] P_Data;
  logic        P_Ready;
  logic        M_Valid;
  logic [31:0] M_Data;
  logic        M_Ready;

  fifo_dual_reader dut (
    .clk(clk), .aclr(aclr), .Start(Start), .Len(Len), .Busy(Busy), .Done(Done),
    .Empty(Empty), .ReadyM(ReadyM), .DataOut1(DataOut1), .DataOut2(DataOut2),
    .Pop1(Pop1), .Pop2(Pop2), .P_Valid(P_Valid), .P_Data(P_Data), .P_Ready(P_Ready),
    .M_Valid(M_Valid), .M_Data(M_Data), .M_Ready(M_Ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pop1_cnt = 0;
  int pop2_cnt = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;

  logic [31:0] mem1 [64];
  logic [31:0] mem2 [64];
  logic [5:0]  wr1, wr2;
  logic [5:0]  rd1 = '0;
  logic [5:0]  rd2 = '0;
  logic [5:0]  cnt2;
  logic [31:0] exp_p [$];
  logic [31:0] exp_m [$];

  // FIFO model: primary side flags empty, secondary side reports one bit per pending entry.
  assign Empty    = (wr1 == rd1);
  assign cnt2     = wr2 - rd2;
  assign DataOut1 = mem1[rd1];
  assign DataOut2 = mem2[rd2];
  always_comb begin
    ReadyM = '0;
    for (int i = 0; i < 16; i++) if (6'(i) < cnt2) ReadyM[i] = 1'b1;
  end

  always @(posedge clk) begin
    if (Pop1) begin rd1 <= rd1 + 6'd1; pop1_cnt <= pop1_cnt + 1; end
    if (Pop2) begin rd2 <= rd2 + 6'd1; pop2_cnt <= pop2_cnt + 1; end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=0x%0h required=none", name, act);
  endtask

  task automatic push(input logic [31:0] d);
    mem1[wr1] = d;
    mem2[wr2] = d;
    wr1 = wr1 + 6'd1;
    wr2 = wr2 + 6'd1;
    exp_p.push_back(d);
    exp_m.push_back(d);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!Done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(Done), 32'd1);
    @(negedge clk);
    check({name, "_drop"}, {30'd0, Done, Busy}, 32'd0);
  endtask

  // Monitor: every accepted word must match the scoreboard head.
  always @(negedge clk) begin
    logic [31:0] e;
    #1;
    if (aclr) begin
      if (P_Valid && P_Ready) begin
        if (exp_p.size() == 0) flag("p_unexpected", P_Data);
        else begin e = exp_p.pop_front(); check("p_data", P_Data, e); end
      end
      if (M_Valid && M_Ready) begin
        if (exp_m.size() == 0) flag("m_unexpected", M_Data);
        else begin e = exp_m.pop_front(); check("m_data", M_Data, e); end
      end
      if (Done) begin
        done_cnt++;
        if (prev_done) flag("done_width", 32'(Done));
      end
      prev_done = Done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

`ifdef FIFO_DUAL_READER_LOCKSTEP_EN
  localparam int BP_M_POPS = 1;
  localparam int BP_M_LEFT = 2;
`else
  localparam int BP_M_POPS = 3;
  localparam int BP_M_LEFT = 0;
`endif

  initial begin
    int p0, m0, d0;
    aclr = 1'b0; Start = 1'b0; Len = '0; P_Ready = 1'b1; M_Ready = 1'b1;
    wr1 = '0; wr2 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_valids", {30'd0, P_Valid, M_Valid}, 32'd0);
    check("rst_p_data", P_Data, 32'd0);
    check("rst_m_data", M_Data, 32'd0);
    check("rst_pops", {30'd0, Pop1, Pop2}, 32'd0);
    aclr = 1'b1;

    // Streaming at full rate, with a stray Start mid-burst
    for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
    @(negedge clk); Start = 1'b1; Len = 8'd4;
    @(negedge clk); Start = 1'b0; p0 = pop1_cnt; m0 = pop2_cnt; d0 = done_cnt;
    check("stream_busy", 32'(Busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("stream_pop1", 32'(Pop1), 32'd1);
      check("stream_pop2", 32'(Pop2), 32'd1);
      if (i == 1) begin Start = 1'b1; Len = 8'd9; end else Start = 1'b0;
      @(negedge clk);
    end
    check("stream_pops_off", {30'd0, Pop1, Pop2}, 32'd0);
    check("stream_done_e0", 32'(Done), 32'd0);
    @(negedge clk);
    check("stream_done_e1", 32'(Done), 32'd0);
    @(negedge clk);
    check("stream_done_e2", 32'(Done), 32'd1);
    @(negedge clk);
    check("stream_idle", {30'd0, Done, Busy}, 32'd0);
    check("stream_pop1_cnt", 32'(pop1_cnt - p0), 32'd4);
    check("stream_pop2_cnt", 32'(pop2_cnt - m0), 32'd4);
    check("stream_left", 32'(exp_p.size() + exp_m.size()), 32'd0);
    check("stream_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Backpressure on the primary port
    for (int i = 0; i < 3; i++) push(32'hB0 + 32'(i));
    P_Ready = 1'b0;
    @(negedge clk); Start = 1'b1; Len = 8'd3;
    @(negedge clk); Start = 1'b0; p0 = pop1_cnt; m0 = pop2_cnt;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_pop1", 32'(Pop1), 32'd0);
      check("bp_hold", P_Data, 32'hB0);
      check("bp_valid", 32'(P_Valid), 32'd1);
      @(negedge clk);
    end
    check("bp_pop1_cnt", 32'(pop1_cnt - p0), 32'd1);
    check("bp_pop2_cnt", 32'(pop2_cnt - m0), 32'(BP_M_POPS));
    check("bp_m_left", 32'(exp_m.size()), 32'(BP_M_LEFT));
    P_Ready = 1'b1;
    wait_done("bp_done");
    check("bp_pop1_total", 32'(pop1_cnt - p0), 32'd3);
    check("bp_pop2_total", 32'(pop2_cnt - m0), 32'd3);
    check("bp_left", 32'(exp_p.size() + exp_m.size()), 32'd0);

    // Empty FIFO, then data arrives; stray Start while waiting
    @(negedge clk); Start = 1'b1; Len = 8'd2;
    @(negedge clk); Start = 1'b0; p0 = pop1_cnt; m0 = pop2_cnt;
    for (int i = 0; i < 10; i++) begin
      check("empty_pops", {30'd0, Pop1, Pop2}, 32'd0);
      if (i == 3) begin Start = 1'b1; Len = 8'd7; end else Start = 1'b0;
      @(negedge clk);
    end
    check("empty_busy", 32'(Busy), 32'd1);
    push(32'hC0);
    push(32'hC1);
    wait_done("empty_done");
    check("empty_pop1_cnt", 32'(pop1_cnt - p0), 32'd2);
    check("empty_pop2_cnt", 32'(pop2_cnt - m0), 32'd2);
    check("empty_left", 32'(exp_p.size() + exp_m.size()), 32'd0);

    // Zero length
    p0 = pop1_cnt; m0 = pop2_cnt;
    @(negedge clk); Start = 1'b1; Len = 8'd0;
    @(negedge clk); Start = 1'b0;
    check("zero_done", 32'(Done), 32'd1);
    check("zero_busy", 32'(Busy), 32'd1);
    check("zero_pops", {30'd0, Pop1, Pop2}, 32'd0);
    @(negedge clk);
    check("zero_idle", {30'd0, Done, Busy}, 32'd0);
    check("zero_pop_cnt", 32'((pop1_cnt - p0) + (pop2_cnt - m0)), 32'd0);

    // Secondary port stalled: pair-wise popping or independent progress
    push(32'hF0);
    push(32'hF1);
    M_Ready = 1'b0;
    @(negedge clk); Start = 1'b1; Len = 8'd2;
    @(negedge clk); Start = 1'b0; p0 = pop1_cnt; m0 = pop2_cnt;
    check("stall_first_pops", {30'd0, Pop1, Pop2}, 32'd3);
    @(negedge clk);
`ifdef FIFO_DUAL_READER_LOCKSTEP_EN
    for (int i = 0; i < 4; i++) begin
      check("lock_pops_held", {30'd0, Pop1, Pop2}, 32'd0);
      @(negedge clk);
    end
    M_Ready = 1'b1;
    #1;
    check("lock_pair_pop", {30'd0, Pop1, Pop2}, 32'd3);
`else
    for (int i = 0; i < 4; i++) begin
      check("indep_pop2_held", 32'(Pop2), 32'd0);
      @(negedge clk);
    end
    check("indep_pop1_cnt", 32'(pop1_cnt - p0), 32'd2);
    check("indep_pop2_cnt", 32'(pop2_cnt - m0), 32'd1);
    M_Ready = 1'b1;
`endif
    wait_done("stall_done");
    check("stall_pop1_total", 32'(pop1_cnt - p0), 32'd2);
    check("stall_pop2_total", 32'(pop2_cnt - m0), 32'd2);
    check("stall_left", 32'(exp_p.size() + exp_m.size()), 32'd0);

    // Reset mid-burst, then restart on the first edge after release
    for (int i = 0; i < 8; i++) push(32'hD0 + 32'(i));
    @(negedge clk); Start = 1'b1; Len = 8'd4;
    @(negedge clk); Start = 1'b0; p0 = pop1_cnt; d0 = done_cnt;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_pops_before", 32'(pop1_cnt - p0), 32'd2);
    #2 aclr = 1'b0;
    #1;
    check("rstmid_pops", {30'd0, Pop1, Pop2}, 32'd0);
    check("rstmid_valids", {30'd0, P_Valid, M_Valid}, 32'd0);
    check("rstmid_busy", 32'(Busy), 32'd0);
    repeat (2) @(negedge clk);
    check("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
    wr1 = rd1;
    wr2 = rd2;
    exp_p.delete();
    exp_m.delete();
    push(32'hE0);
    push(32'hE1);
    p0 = pop1_cnt; m0 = pop2_cnt;
    aclr = 1'b1; Start = 1'b1; Len = 8'd2;
    @(negedge clk); Start = 1'b0;
    check("rstmid_restart_busy", 32'(Busy), 32'd1);
    wait_done("rstmid_done");
    check("rstmid_pop1_cnt", 32'(pop1_cnt - p0), 32'd2);
    check("rstmid_pop2_cnt", 32'(pop2_cnt - m0), 32'd2);
    check("rstmid_left", 32'(exp_p.size() + exp_m.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
